// File: rtl/bcd_sum_conv.sv
// Adds two unsigned operands and converts the sum to two BCD digits with a sequential
// double-dabble engine. Optional START_EDGE_EN treats start as an async pushbutton level.
module bcd_sum_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SumW = WIDTH + 1;
  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [SumW-1:0]  sum_q, sum_d;
  logic [7:0]       bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             start_qual;

`ifdef START_EDGE_EN
  logic [2:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], start};
    end
  end

  // Rising edge of the synchronised level: one qualifier pulse per press.
  assign start_qual = sync_q[1] & ~sync_q[2];
`else
  assign start_qual = start;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sum_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_qual) state_d = StShift;
      StShift: if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sum_d   = sum_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    unique case (state_q)
      StIdle: begin
        if (start_qual) begin
          sum_d  = SumW'(a) + SumW'(b);
          bcd_d  = '0;
          cnt_d  = CntInit;
          busy_d = 1'b1;
        end
      end
      StShift: begin
        bcd_d  = {bcd_adj[6:0], sum_q[SumW-1]};
        sum_d  = {sum_q[SumW-2:0], 1'b0};
        cnt_d  = cnt_q - CntW'(1);
        busy_d = 1'b1;
      end
      StDone: begin
        // Digits change only here so the display never sees partial values.
        tens_d = bcd_q[7:4];
        ones_d = bcd_q[3:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
